tm_inference_sequencer: RTL and testbench

Time-multiplexed Tsetlin Machine inference controller. It accepts one feature vector and streams per-clause exclude masks from an external state memory, one clause per cycle. It evaluates each clause, accumulates signed class votes and reports the argmax class. It replaces the fully-parallel flat-bus inference datapath wherever state storage lives in RAM.

---
 rtl/tm_pkg.sv | 41 ++++
 rtl/tm_inference_sequencer_if.sv | 38 +++
 rtl/tm_clause_eval.sv | 27 ++
 rtl/tm_inference_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_tm_inference_sequencer.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/tm_pkg.sv
// Shared types and helpers for the time-multiplexed Tsetlin Machine inference blocks.
package tm_pkg;

  // Sequencer control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } tm_state_e;

  // Literal ordering: positive literals x[i] occupy the low half, negated ~x[i] the high half.
  localparam int LIT_POS_BASE = 0;

  function automatic int lit_pos(input int i);
    return LIT_POS_BASE + i;
  endfunction

  function automatic int lit_neg(input int i, input int n_features);
    return n_features + i;
  endfunction

  // $clog2 clamped to at least one bit so single-entry ranges still get a port.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  // Signed score width: enough for +/- N_CLAUSES/2 with headroom.
  function automatic int score_width(input int n_clauses);
    return $clog2(n_clauses + 1) + 1;
  endfunction

  // Polarity rule: even clauses vote for the class, odd clauses vote against it.
  function automatic logic signed [1:0] clause_vote(input logic odd_clause, input logic clause_out);
    if (!clause_out) begin
      return 2'sb00;
    end
    return odd_clause ? 2'sb11 : 2'sb01;
  endfunction

endpackage

// File: rtl/tm_inference_sequencer_if.sv
// Feature, state-memory and result handshake bundle for the inference sequencer.
interface tm_inference_sequencer_if
  import tm_pkg::*;
#(
  parameter int N_FEATURES = 2,
  parameter int N_CLAUSES  = 4,
  parameter int N_CLASSES  = 2
) ();

  localparam int AW = clog2_min1(N_CLASSES * N_CLAUSES);
  localparam int CW = clog2_min1(N_CLASSES);
  localparam int SW = score_width(N_CLAUSES);

  logic                      feat_valid;
  logic                      feat_ready;
  logic [N_FEATURES-1:0]     features;
  logic                      mem_rd_en;
  logic [AW-1:0]             mem_addr;
  logic [2*N_FEATURES-1:0]   mem_rdata;
  logic                      result_valid;
  logic                      result_ready;
  logic [CW-1:0]             class_idx;
  logic signed [SW-1:0]      class_score;
  logic                      busy;

  // Sequencer side: consumes features and memory data, drives reads and results.
  modport master (
    input  feat_valid, features, mem_rdata, result_ready,
    output feat_ready, mem_rd_en, mem_addr, result_valid, class_idx, class_score, busy
  );

  // Environment side: feature producer, state memory and result consumer.
  modport slave (
    output feat_valid, features, mem_rdata, result_ready,
    input  feat_ready, mem_rd_en, mem_addr, result_valid, class_idx, class_score, busy
  );

endinterface

// File: rtl/tm_clause_eval.sv
// Combinational clause evaluation: AND of included literals, empty clause yields 0.
module tm_clause_eval
  import tm_pkg::*;
#(
  parameter int N_FEATURES = 2
) (
  input  logic [N_FEATURES-1:0]   features,
  input  logic [2*N_FEATURES-1:0] exclude,
  output logic                    clause_out
);

  logic [2*N_FEATURES-1:0] lits;
  logic [2*N_FEATURES-1:0] lit_ok;

  genvar gi;
  generate
    for (gi = 0; gi < N_FEATURES; gi++) begin : g_lit
      assign lits[lit_pos(gi)]             = features[gi];
      assign lits[lit_neg(gi, N_FEATURES)] = ~features[gi];
    end
  endgenerate

  // An excluded literal is forced true so it cannot veto the AND.
  assign lit_ok     = lits | exclude;
  assign clause_out = (&lit_ok) & ~(&exclude);

endmodule

// File: rtl/tm_inference_sequencer.sv
// Streams clause exclude masks from state RAM, one per cycle, accumulates signed
// class votes and reports the argmax class once all clauses are evaluated.
module tm_inference_sequencer
  import tm_pkg::*;
#(
  parameter int N_FEATURES = 2,
  parameter int N_CLAUSES  = 4,
  parameter int N_CLASSES  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  tm_inference_sequencer_if.master bus
);

  localparam int M  = N_CLASSES * N_CLAUSES;
  localparam int AW = clog2_min1(M);
  localparam int CW = clog2_min1(N_CLASSES);
  localparam int SW = score_width(N_CLAUSES);

  tm_state_e             state_q, state_d;
  logic [N_FEATURES-1:0] feat_q, feat_d;
  logic                  feat_ready_q, feat_ready_d;
  logic                  mem_rd_en_q, mem_rd_en_d;
  logic [AW-1:0]         mem_addr_q, mem_addr_d;
  logic                  busy_q, busy_d;
  logic                  result_valid_q, result_valid_d;
  logic [CW-1:0]         class_idx_q, class_idx_d;
  logic signed [SW-1:0]  class_score_q, class_score_d;
  logic [AW-1:0]         issue_cnt_q, issue_cnt_d;
  logic                  eval_vld_q, eval_vld_d;
  logic [AW-1:0]         eval_addr_q, eval_addr_d;
  logic signed [SW-1:0]  sum_q, sum_d;
  logic signed [SW-1:0]  best_score_q, best_score_d;
  logic [CW-1:0]         best_idx_q, best_idx_d;

  // Evaluation stage decode, driven by the address registered one cycle after issue.
  int                    eval_class;
  int                    eval_clause;
  logic                  clause_bit;
  logic signed [1:0]     vote_raw;
  logic signed [SW-1:0]  vote;
  logic signed [SW-1:0]  sum_total;
  logic                  is_last_clause;
  logic                  is_final;

  assign eval_class     = int'(eval_addr_q) / N_CLAUSES;
  assign eval_clause    = int'(eval_addr_q) % N_CLAUSES;
  assign is_last_clause = (eval_clause == N_CLAUSES - 1);
  assign is_final       = (eval_addr_q == AW'(M - 1));

  tm_clause_eval #(
    .N_FEATURES (N_FEATURES)
  ) u_clause_eval (
    .features   (feat_q),
    .exclude    (bus.mem_rdata),
    .clause_out (clause_bit)
  );

  assign vote_raw  = clause_vote(eval_clause[0], clause_bit);
  assign vote      = {{(SW-2){vote_raw[1]}}, vote_raw};
  assign sum_total = sum_q + vote;

  // Next-state logic for the control FSM, the issue counter and the vote accumulators.
  always_comb begin
    state_d        = state_q;
    feat_d         = feat_q;
    feat_ready_d   = feat_ready_q;
    mem_rd_en_d    = mem_rd_en_q;
    mem_addr_d     = mem_addr_q;
    busy_d         = busy_q;
    result_valid_d = result_valid_q;
    class_idx_d    = class_idx_q;
    class_score_d  = class_score_q;
    issue_cnt_d    = issue_cnt_q;
    sum_d          = sum_q;
    best_score_d   = best_score_q;
    best_idx_d     = best_idx_q;
    eval_vld_d     = mem_rd_en_q;
    eval_addr_d    = mem_addr_q;

    // Accumulate this clause; at the end of a class fold the sum into the running best.
    if (eval_vld_q) begin
      if (is_last_clause) begin
        sum_d = '0;
        if ((eval_class == 0) || (sum_total > best_score_q)) begin
          best_score_d = sum_total;
          best_idx_d   = CW'(eval_class);
        end
      end else begin
        sum_d = sum_total;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (bus.feat_valid && feat_ready_q) begin
          feat_d       = bus.features;
          state_d      = ST_RUN;
          feat_ready_d = 1'b0;
          busy_d       = 1'b1;
          issue_cnt_d  = '0;
          sum_d        = '0;
        end
      end
      ST_RUN: begin
        mem_rd_en_d = 1'b1;
        mem_addr_d  = issue_cnt_q;
        if (issue_cnt_q == AW'(M - 1)) begin
          state_d = ST_DRAIN;
        end else begin
          issue_cnt_d = issue_cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        mem_rd_en_d = 1'b0;
        if (eval_vld_q && is_final) begin
          state_d        = ST_DONE;
          busy_d         = 1'b0;
          result_valid_d = 1'b1;
          class_idx_d    = best_idx_d;
          class_score_d  = best_score_d;
        end
      end
      ST_DONE: begin
        if (bus.result_ready) begin
          state_d        = ST_IDLE;
          result_valid_d = 1'b0;
          feat_ready_d   = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register; reset aborts any run in flight without producing a result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      feat_q         <= '0;
      feat_ready_q   <= 1'b1;
      mem_rd_en_q    <= 1'b0;
      mem_addr_q     <= '0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      class_idx_q    <= '0;
      class_score_q  <= '0;
      issue_cnt_q    <= '0;
      eval_vld_q     <= 1'b0;
      eval_addr_q    <= '0;
      sum_q          <= '0;
      best_score_q   <= '0;
      best_idx_q     <= '0;
    end else begin
      state_q        <= state_d;
      feat_q         <= feat_d;
      feat_ready_q   <= feat_ready_d;
      mem_rd_en_q    <= mem_rd_en_d;
      mem_addr_q     <= mem_addr_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
      class_idx_q    <= class_idx_d;
      class_score_q  <= class_score_d;
      issue_cnt_q    <= issue_cnt_d;
      eval_vld_q     <= eval_vld_d;
      eval_addr_q    <= eval_addr_d;
      sum_q          <= sum_d;
      best_score_q   <= best_score_d;
      best_idx_q     <= best_idx_d;
    end
  end

  assign bus.feat_ready   = feat_ready_q;
  assign bus.mem_rd_en    = mem_rd_en_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.busy         = busy_q;
  assign bus.result_valid = result_valid_q;
  assign bus.class_idx    = class_idx_q;
  assign bus.class_score  = class_score_q;

endmodule

// File: tb/tb_tm_inference_sequencer.sv
// Directed bench for the inference sequencer with a registered-read state memory model.
module tb_tm_inference_sequencer;

  logic clk;
  logic rst_n;

  tm_inference_sequencer_if #(.N_FEATURES(2), .N_CLAUSES(4), .N_CLASSES(2)) bus ();

  tm_inference_sequencer #(.N_FEATURES(2), .N_CLAUSES(4), .N_CLASSES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] mem [0:7];
  logic [3:0] xor_masks [0:7];

  int acc_edge [0:1];
  int rv_edge  [0:1];
  int r_idx    [0:1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // State memory: registered read, garbage when not strobed.
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
    else               bus.mem_rdata <= 4'($urandom);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Offer one feature vector, trace the read sequence and check the result.
  task automatic run_vec(input string tag, input logic [1:0] f, input int exp_idx,
                         input int exp_score, input bit do_ack);
    int cyc;
    int rv_cyc;
    int n_reads;
    int order_ok;
    @(negedge clk);
    check({tag, "/feat_ready_idle"}, int'(bus.feat_ready), 1);
    bus.feat_valid = 1'b1;
    bus.features   = f;
    @(negedge clk);
    bus.feat_valid = 1'b0;
    cyc = 0; rv_cyc = -1; n_reads = 0; order_ok = 1;
    check({tag, "/busy_c0"}, int'(bus.busy), 1);
    while (rv_cyc < 0 && cyc <= 40) begin
      if (bus.result_valid) begin
        rv_cyc = cyc;
      end else begin
        if (bus.mem_rd_en) begin
          if (int'(bus.mem_addr) != cyc - 1) order_ok = 0;
          n_reads++;
        end
        @(negedge clk);
        cyc++;
      end
    end
    check({tag, "/latency"}, rv_cyc, 10);
    check({tag, "/n_reads"}, n_reads, 8);
    check({tag, "/addr_order"}, order_ok, 1);
    check({tag, "/class_idx"}, int'(bus.class_idx), exp_idx);
    check({tag, "/class_score"}, int'($signed(bus.class_score)), exp_score);
    $display("txn %s features=%b idx=%0d score=%0d latency=%0d", tag, f,
             bus.class_idx, $signed(bus.class_score), rv_cyc);
    if (do_ack) begin
      bus.result_ready = 1'b1;
      @(negedge clk);
      bus.result_ready = 1'b0;
      check({tag, "/rv_drop"}, int'(bus.result_valid), 0);
      check({tag, "/feat_ready_back"}, int'(bus.feat_ready), 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int na;
    int nr;
    int c;
    int rd_seen;
    xor_masks[0] = 4'b1100; xor_masks[1] = 4'b0110;
    xor_masks[2] = 4'b0011; xor_masks[3] = 4'b1001;
    xor_masks[4] = 4'b0110; xor_masks[5] = 4'b1100;
    xor_masks[6] = 4'b1001; xor_masks[7] = 4'b0011;
    for (int i = 0; i < 8; i++) mem[i] = xor_masks[i];

    rst_n = 1'b0;
    bus.feat_valid   = 1'b0;
    bus.features     = 2'b00;
    bus.result_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst/feat_ready", int'(bus.feat_ready), 1);
    check("rst/mem_rd_en", int'(bus.mem_rd_en), 0);
    check("rst/mem_addr", int'(bus.mem_addr), 0);
    check("rst/result_valid", int'(bus.result_valid), 0);
    check("rst/class_idx", int'(bus.class_idx), 0);
    check("rst/class_score", int'($signed(bus.class_score)), 0);
    check("rst/busy", int'(bus.busy), 0);
    rst_n = 1'b1;

    // XOR truth table.
    run_vec("x01", 2'b01, 1, 1, 1'b1);
    run_vec("x11", 2'b11, 0, 1, 1'b1);
    run_vec("x00", 2'b00, 0, 1, 1'b1);
    run_vec("x10", 2'b10, 1, 1, 1'b1);

    // Empty clauses everywhere: all scores zero, tie resolves to class 0.
    for (int i = 0; i < 8; i++) mem[i] = 4'b1111;
    run_vec("empty", 2'b01, 0, 0, 1'b1);
    for (int i = 0; i < 8; i++) mem[i] = xor_masks[i];

    // Back-pressure: result held, feat_valid toggled, no new reads.
    run_vec("hold", 2'b01, 1, 1, 1'b0);
    bus.features = 2'b11;
    rd_seen = 0;
    for (int i = 0; i < 5; i++) begin
      bus.feat_valid = ~bus.feat_valid;
      @(negedge clk);
      if (bus.mem_rd_en) rd_seen++;
      check("hold/result_valid", int'(bus.result_valid), 1);
      check("hold/feat_ready", int'(bus.feat_ready), 0);
      check("hold/class_idx", int'(bus.class_idx), 1);
      check("hold/class_score", int'($signed(bus.class_score)), 1);
    end
    check("hold/no_reads", rd_seen, 0);
    bus.feat_valid   = 1'b0;
    bus.result_ready = 1'b1;
    @(negedge clk);
    bus.result_ready = 1'b0;
    check("hold/rv_drop", int'(bus.result_valid), 0);
    check("hold/feat_ready_back", int'(bus.feat_ready), 1);
    $display("txn hold released");

    // Reset in the middle of a run.
    bus.feat_valid = 1'b1;
    bus.features   = 2'b01;
    @(negedge clk);
    bus.feat_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("abort/busy_before", int'(bus.busy), 1);
    check("abort/rd_en_before", int'(bus.mem_rd_en), 1);
    rst_n = 1'b0;
    #1;
    check("abort/mem_rd_en", int'(bus.mem_rd_en), 0);
    check("abort/busy", int'(bus.busy), 0);
    check("abort/result_valid", int'(bus.result_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort/feat_ready", int'(bus.feat_ready), 1);
    $display("txn abort by reset");
    run_vec("post_abort", 2'b01, 1, 1, 1'b1);

    // Back-to-back with result_ready tied high and feat_valid held.
    @(negedge clk);
    bus.result_ready = 1'b1;
    bus.feat_valid   = 1'b1;
    bus.features     = 2'b01;
    na = 0; nr = 0; c = 0;
    while (nr < 2 && c < 80) begin
      if (bus.result_valid) begin
        rv_edge[nr] = c;
        r_idx[nr]   = int'(bus.class_idx);
        nr++;
        if (nr == 2) bus.feat_valid = 1'b0;
      end
      if (bus.feat_ready && bus.feat_valid && na < 2) begin
        acc_edge[na] = c + 1;
        na++;
      end
      @(negedge clk);
      c++;
      if (na >= 1) bus.features = 2'b11;
    end
    bus.feat_valid   = 1'b0;
    bus.result_ready = 1'b0;
    check("b2b/n_results", nr, 2);
    check("b2b/n_accepts", na, 2);
    if (nr == 2 && na == 2) begin
      check("b2b/idx_first", r_idx[0], 1);
      check("b2b/idx_second", r_idx[1], 0);
      check("b2b/latency", rv_edge[0] - acc_edge[0], 10);
      check("b2b/reaccept_gap", acc_edge[1] - rv_edge[0], 2);
      $display("txn b2b results idx=%0d,%0d accepts at %0d,%0d", r_idx[0], r_idx[1],
               acc_edge[0], acc_edge[1]);
    end
    repeat (3) @(negedge clk);
    check("end/feat_ready", int'(bus.feat_ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
